ds_dac_sequencer: RTL and testbench

- Sample scheduler and buffer in front of the delta-sigma 1-bit DAC.
- Accepts PCM samples from a bus-side writer into a small FIFO and primes the buffer before playback.
- Releases one sample per programmable sample period onto the DAC's PCM input.
- Detects, counts and recovers from underrun and overflow; sits between the MMIO audio core and the DAC.

---
 rtl/ds_dac_pkg.sv | 14 +
 rtl/ds_sample_fifo.sv | 77 +++++++
 rtl/ds_dac_sequencer.sv | 174 +++++++++++++++++
 tb/tb_ds_dac_sequencer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ds_dac_pkg.sv
// Shared types for the delta-sigma DAC sample sequencer.
//   state_t : playback FSM states (IDLE, PRIME, PLAY)
//   URUN_W  : width of the saturating underrun counter
package ds_dac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    PLAY  = 2'd2
  } state_t;

  localparam int URUN_W = 8;

endpackage

// File: rtl/ds_sample_fifo.sv
// Synchronous sample FIFO with a registered head output.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   wr, wr_data  : enqueue request (accepted when not full, or when popping)
//   rd           : dequeue request (ignored when empty)
//   flush        : empties the FIFO; overrides wr and rd in the same cycle
//   full, empty  : occupancy flags
//   level        : occupancy 0..2**A
//   head         : oldest stored sample, valid whenever empty is low
module ds_sample_fifo #(
  parameter int A = 3,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr,
  input  logic [W-1:0] wr_data,
  input  logic         rd,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output logic [A:0]   level,
  output logic [W-1:0] head
);

  localparam int         DEPTH    = 2 ** A;
  localparam logic [A:0] FULL_LVL = (A + 1)'(DEPTH);
  localparam logic [A-1:0] PTR_ONE = (A)'(1);
  localparam logic [A:0]   CNT_ONE = (A + 1)'(1);

  logic [W-1:0] mem [DEPTH];
  logic [A-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [A:0]   count_reg;
  logic [W-1:0] head_reg;
  logic         wr_en, rd_en;

  assign full  = (count_reg == FULL_LVL);
  assign empty = (count_reg == '0);
  assign level = count_reg;
  assign head  = head_reg;

  assign rd_en = rd && !empty && !flush;
  // A simultaneous pop frees a slot, so a write into a full FIFO is still taken.
  assign wr_en = wr && !flush && (!full || rd_en);

  assign rd_ptr_next = flush ? '0 : (rd_en ? rd_ptr_reg + PTR_ONE : rd_ptr_reg);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      if (flush) begin
        wr_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
        case ({wr_en, rd_en})
          2'b10:   count_reg <= count_reg + CNT_ONE;
          2'b01:   count_reg <= count_reg - CNT_ONE;
          default: count_reg <= count_reg;
        endcase
      end
      // Read the slot that will be the head after this edge; if that slot is
      // being written right now (FIFO empty or draining), forward the write.
      head_reg <= (wr_en && (wr_ptr_reg == rd_ptr_next)) ? wr_data : mem[rd_ptr_next];
    end
  end

endmodule

// File: rtl/ds_dac_sequencer.sv
// Sample scheduler and buffer in front of the delta-sigma 1-bit DAC.
// Buffers PCM samples, primes the buffer, then releases one sample every
// div+1 clocks onto pcm_out. Underrun and overflow are detected and counted.
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   en                : playback enable (level); low flushes and idles
//   div               : sample period minus one, in clk cycles
//   hold_last         : on underrun, 1 = keep last sample, 0 = output zero
//   wr, wr_data       : sample write strobe and data
//   clr_status        : clears underrun, overflow and urun_cnt
//   full, level       : FIFO status
//   playing           : high in PLAY
//   underrun,overflow : sticky status flags
//   urun_cnt          : saturating underrun count
//   sample_tick       : pulses in the cycle pcm_out takes a new sample
//   pcm_out           : registered sample to the DAC
module ds_dac_sequencer
  import ds_dac_pkg::*;
#(
  parameter int W         = 16,
  parameter int A         = 3,
  parameter int D         = 16,
  parameter int PRIME_LVL = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [D-1:0]      div,
  input  logic              hold_last,
  input  logic              wr,
  input  logic [W-1:0]      wr_data,
  input  logic              clr_status,
  output logic              full,
  output logic [A:0]        level,
  output logic              playing,
  output logic              underrun,
  output logic              overflow,
  output logic [URUN_W-1:0] urun_cnt,
  output logic              sample_tick,
  output logic [W-1:0]      pcm_out
);

  localparam logic [A:0]   PRIME_LVL_V = (A + 1)'(PRIME_LVL);
  localparam logic [D-1:0] DIV_ONE     = (D)'(1);

  state_t              state_reg, state_next;
  logic [D-1:0]        cnt_reg, cnt_next;
  logic [W-1:0]        pcm_reg, pcm_next;
  logic                tick_reg, tick_next;
  logic                underrun_reg, underrun_next;
  logic                overflow_reg, overflow_next;
  logic [URUN_W-1:0]   urun_cnt_reg, urun_cnt_next;

  logic                pop_req, flush, urun_evt, ovf_evt;
  logic                fifo_wr, fifo_rd, fifo_full, fifo_empty;
  logic [A:0]          fifo_level;
  logic [W-1:0]        fifo_head;

  ds_sample_fifo #(.A(A), .W(W)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr      (fifo_wr),
    .wr_data (wr_data),
    .rd      (fifo_rd),
    .flush   (flush),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level),
    .head    (fifo_head)
  );

  // Disabling only flushes when leaving PRIME/PLAY, so the buffer can be
  // prefilled while idle with en low.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pcm_next   = pcm_reg;
    tick_next  = 1'b0;
    pop_req    = 1'b0;
    flush      = 1'b0;
    urun_evt   = 1'b0;
    case (state_reg)
      IDLE: begin
        pcm_next = '0;
        cnt_next = '0;
        if (en) state_next = PRIME;
      end
      PRIME: begin
        if (!en) begin
          state_next = IDLE;
          flush      = 1'b1;
          pcm_next   = '0;
          cnt_next   = '0;
        end else if (fifo_level >= PRIME_LVL_V) begin
          pop_req    = 1'b1;
          pcm_next   = fifo_head;
          tick_next  = 1'b1;
          cnt_next   = '0;
          state_next = PLAY;
        end
      end
      PLAY: begin
        if (!en) begin
          state_next = IDLE;
          flush      = 1'b1;
          pcm_next   = '0;
          cnt_next   = '0;
        end else if (cnt_reg >= div) begin
          // >= rather than == so a shrinking div never skips a period.
          cnt_next = '0;
          pop_req  = 1'b1;
          if (!fifo_empty) begin
            pcm_next  = fifo_head;
            tick_next = 1'b1;
          end else begin
            urun_evt   = 1'b1;
            pcm_next   = hold_last ? pcm_reg : '0;
            state_next = PRIME;
          end
        end else begin
          cnt_next = cnt_reg + DIV_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign fifo_rd = pop_req && !fifo_empty;
  assign fifo_wr = wr && !flush;
  assign ovf_evt = fifo_wr && fifo_full && !fifo_rd;

  // New events take priority over a coincident clear.
  always_comb begin
    underrun_next = clr_status ? 1'b0 : underrun_reg;
    overflow_next = clr_status ? 1'b0 : overflow_reg;
    urun_cnt_next = clr_status ? '0 : urun_cnt_reg;
    if (urun_evt) begin
      underrun_next = 1'b1;
      if (clr_status)              urun_cnt_next = (URUN_W)'(1);
      else if (urun_cnt_reg != '1) urun_cnt_next = urun_cnt_reg + (URUN_W)'(1);
    end
    if (ovf_evt) overflow_next = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      pcm_reg      <= '0;
      tick_reg     <= 1'b0;
      underrun_reg <= 1'b0;
      overflow_reg <= 1'b0;
      urun_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      pcm_reg      <= pcm_next;
      tick_reg     <= tick_next;
      underrun_reg <= underrun_next;
      overflow_reg <= overflow_next;
      urun_cnt_reg <= urun_cnt_next;
    end
  end

  assign full        = fifo_full;
  assign level       = fifo_level;
  assign playing     = (state_reg == PLAY);
  assign underrun    = underrun_reg;
  assign overflow    = overflow_reg;
  assign urun_cnt    = urun_cnt_reg;
  assign sample_tick = tick_reg;
  assign pcm_out     = pcm_reg;

endmodule

// File: tb/tb_ds_dac_sequencer.sv
// Self-checking bench for ds_dac_sequencer. Written samples are queued as
// expected playback values and compared when sample_tick is observed.
module tb_ds_dac_sequencer;

  localparam int W = 16;
  localparam int A = 3;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         en = 1'b0;
  logic [D-1:0] div = '0;
  logic         hold_last = 1'b0;
  logic         wr = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         clr_status = 1'b0;
  logic         full;
  logic [A:0]   level;
  logic         playing;
  logic         underrun;
  logic         overflow;
  logic [7:0]   urun_cnt;
  logic         sample_tick;
  logic [W-1:0] pcm_out;

  int vectors = 0;
  int miscompares = 0;
  int exp_urun = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;

  ds_dac_sequencer #(.W(W), .A(A), .D(D), .PRIME_LVL(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .div         (div),
    .hold_last   (hold_last),
    .wr          (wr),
    .wr_data     (wr_data),
    .clr_status  (clr_status),
    .full        (full),
    .level       (level),
    .playing     (playing),
    .underrun    (underrun),
    .overflow    (overflow),
    .urun_cnt    (urun_cnt),
    .sample_tick (sample_tick),
    .pcm_out     (pcm_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance negedge by negedge until sample_tick is seen or budget expires.
  task automatic wait_tick(input int budget, output bit got, output int waited);
    got = 1'b0;
    waited = 0;
    while (!got && waited < budget) begin
      @(negedge clk);
      waited++;
      if (sample_tick) got = 1'b1;
    end
  endtask

  task automatic write_sample(input logic [W-1:0] d, input bit kept);
    wr = 1'b1;
    wr_data = d;
    if (kept) exp_q.push_back(d);
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({level, full, playing, underrun, overflow, urun_cnt, sample_tick, pcm_out} !== 33'd0) begin
      miscompares++;
      $display("FAIL reset_state: outputs=%h required=0", {level, full, playing, underrun, overflow, urun_cnt, sample_tick, pcm_out});
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_prefill();
    div = 16'd9;
    en = 1'b1;
    for (int i = 0; i < 3; i++) write_sample(16'h0A01 + 16'(i), 1'b1);
    vectors++;
    if ({playing, pcm_out, level} !== {1'b0, 16'h0000, 4'd3}) begin
      miscompares++;
      $display("FAIL prefill_hold: playing=%b pcm_out=%h level=%0d required 0/0000/3", playing, pcm_out, level);
    end
    write_sample(16'h0A04, 1'b1);
    vectors++;
    if (playing !== 1'b0) begin
      miscompares++;
      $display("FAIL prefill_edge: playing=%b required 0", playing);
    end
    @(negedge clk);
    exp_v = exp_q.pop_front();
    $display("tick prefill pcm_out=%h expected=%h", pcm_out, exp_v);
    vectors++;
    if ({playing, sample_tick, pcm_out} !== {1'b1, 1'b1, exp_v}) begin
      miscompares++;
      $display("FAIL prefill_start: playing=%b tick=%b pcm_out=%h required 1/1/%h", playing, sample_tick, pcm_out, exp_v);
    end
  endtask

  task automatic test_reset_mid_play();
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({level, full, playing, underrun, overflow, urun_cnt, sample_tick, pcm_out} !== 33'd0) begin
      miscompares++;
      $display("FAIL reset_mid_play: outputs=%h required=0", {level, full, playing, underrun, overflow, urun_cnt, sample_tick, pcm_out});
    end
    en = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cadence();
    bit got;
    int waited;
    div = 16'd9;
    for (int i = 0; i < 8; i++) write_sample(16'h0100 * 16'(i + 1), 1'b1);
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_tick((k == 0) ? 4 : 12, got, waited);
      vectors++;
      if (!got || exp_q.size() == 0 || (k > 0 && waited != 10)) begin
        miscompares++;
        $display("FAIL cadence_period: tick=%b after %0d cycles, required tick after 10", got, waited);
      end else begin
        exp_v = exp_q.pop_front();
        $display("tick cadence pcm_out=%h expected=%h", pcm_out, exp_v);
        vectors++;
        if (pcm_out !== exp_v) begin
          miscompares++;
          $display("FAIL cadence_pcm: pcm_out=%h required=%h", pcm_out, exp_v);
        end
      end
    end
    vectors++;
    if (underrun !== 1'b0) begin
      miscompares++;
      $display("FAIL cadence_underrun: underrun=%b required 0", underrun);
    end
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_underrun(input bit hold);
    bit got;
    bit seen;
    int waited;
    logic [W-1:0] exp_pcm;
    hold_last = hold;
    div = 16'd3;
    for (int i = 0; i < 4; i++) write_sample(16'h0100 * 16'(i + 1), 1'b1);
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_tick(6, got, waited);
      vectors++;
      if (!got || exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL underrun_tick: tick=%b after %0d cycles, required a tick", got, waited);
      end else begin
        exp_v = exp_q.pop_front();
        $display("tick underrun hold=%0d pcm_out=%h expected=%h", hold, pcm_out, exp_v);
        vectors++;
        if (pcm_out !== exp_v) begin
          miscompares++;
          $display("FAIL underrun_pcm: pcm_out=%h required=%h", pcm_out, exp_v);
        end
      end
    end
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (sample_tick) seen = 1'b1;
    end
    exp_urun++;
    exp_pcm = hold ? 16'h0400 : 16'h0000;
    vectors++;
    if ({underrun, urun_cnt, pcm_out, playing, seen} !== {1'b1, 8'(exp_urun), exp_pcm, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL underrun_event: underrun=%b cnt=%0d pcm_out=%h playing=%b tick=%b required 1/%0d/%h/0/0",
               underrun, urun_cnt, pcm_out, playing, seen, exp_urun, exp_pcm);
    end
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_overflow();
    bit got;
    int waited;
    for (int i = 0; i < 9; i++) write_sample(16'h1000 + 16'(i), i < 8);
    vectors++;
    if ({full, level, overflow} !== {1'b1, 4'd8, 1'b1}) begin
      miscompares++;
      $display("FAIL overflow_flags: full=%b level=%0d overflow=%b required 1/8/1", full, level, overflow);
    end
    div = 16'd1;
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_tick(4, got, waited);
      vectors++;
      if (!got || exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL overflow_tick: tick=%b after %0d cycles, required a tick", got, waited);
      end else begin
        exp_v = exp_q.pop_front();
        $display("tick overflow pcm_out=%h expected=%h", pcm_out, exp_v);
        vectors++;
        if (pcm_out !== exp_v) begin
          miscompares++;
          $display("FAIL overflow_pcm: pcm_out=%h required=%h", pcm_out, exp_v);
        end
      end
    end
    wait_tick(4, got, waited);
    exp_urun++;
    vectors++;
    if (got || urun_cnt !== 8'(exp_urun)) begin
      miscompares++;
      $display("FAIL overflow_dropped: extra tick=%b pcm_out=%h urun_cnt=%0d required no tick, cnt %0d",
               got, pcm_out, urun_cnt, exp_urun);
    end
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clear();
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    exp_urun = 0;
    vectors++;
    if ({underrun, overflow, urun_cnt} !== 10'd0) begin
      miscompares++;
      $display("FAIL clear_status: underrun=%b overflow=%b urun_cnt=%0d required 0/0/0", underrun, overflow, urun_cnt);
    end
  endtask

  task automatic test_full_write();
    bit got;
    int waited;
    for (int i = 0; i < 8; i++) write_sample(16'h2000 + 16'(i), 1'b1);
    div = 16'd3;
    en = 1'b1;
    wait_tick(4, got, waited);
    vectors++;
    if (!got || exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL full_first_tick: tick=%b after %0d cycles, required a tick", got, waited);
    end else begin
      exp_v = exp_q.pop_front();
      $display("tick full_write pcm_out=%h expected=%h", pcm_out, exp_v);
      vectors++;
      if (pcm_out !== exp_v) begin
        miscompares++;
        $display("FAIL full_first_pcm: pcm_out=%h required=%h", pcm_out, exp_v);
      end
    end
    write_sample(16'h2008, 1'b1);
    vectors++;
    if ({full, level} !== {1'b1, 4'd8}) begin
      miscompares++;
      $display("FAIL full_refill: full=%b level=%0d required 1/8", full, level);
    end
    @(negedge clk);
    @(negedge clk);
    write_sample(16'h2009, 1'b1);
    exp_v = exp_q.pop_front();
    $display("tick full_write pcm_out=%h expected=%h", pcm_out, exp_v);
    vectors++;
    if ({sample_tick, pcm_out, level, overflow} !== {1'b1, exp_v, 4'd8, 1'b0}) begin
      miscompares++;
      $display("FAIL full_write_pop: tick=%b pcm_out=%h level=%0d overflow=%b required 1/%h/8/0",
               sample_tick, pcm_out, level, overflow, exp_v);
    end
  endtask

  task automatic test_disable();
    bit got;
    int waited;
    for (int k = 0; k < 3; k++) begin
      wait_tick(6, got, waited);
      vectors++;
      if (!got || exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL disable_tick: tick=%b after %0d cycles, required a tick", got, waited);
      end else begin
        exp_v = exp_q.pop_front();
        $display("tick disable pcm_out=%h expected=%h", pcm_out, exp_v);
        vectors++;
        if (pcm_out !== exp_v) begin
          miscompares++;
          $display("FAIL disable_pcm: pcm_out=%h required=%h", pcm_out, exp_v);
        end
      end
    end
    vectors++;
    if (level !== 4'd5) begin
      miscompares++;
      $display("FAIL disable_level_before: level=%0d required 5", level);
    end
    en = 1'b0;
    write_sample(16'hDEAD, 1'b0);
    exp_q.delete();
    vectors++;
    if ({playing, level, pcm_out, overflow} !== {1'b0, 4'd0, 16'h0000, 1'b0}) begin
      miscompares++;
      $display("FAIL disable_flush: playing=%b level=%0d pcm_out=%h overflow=%b required 0/0/0000/0",
               playing, level, pcm_out, overflow);
    end
  endtask

  task automatic test_clr_vs_underrun();
    bit got;
    int waited;
    div = 16'd3;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) write_sample(16'h3000 + 16'(i), 1'b1);
      en = 1'b1;
      for (int k = 0; k < 4; k++) begin
        wait_tick(6, got, waited);
        vectors++;
        if (!got || exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL clr_urun_tick: tick=%b after %0d cycles, required a tick", got, waited);
        end else begin
          exp_v = exp_q.pop_front();
          $display("tick clr_vs_underrun round=%0d pcm_out=%h expected=%h", r, pcm_out, exp_v);
          vectors++;
          if (pcm_out !== exp_v) begin
            miscompares++;
            $display("FAIL clr_urun_pcm: pcm_out=%h required=%h", pcm_out, exp_v);
          end
        end
      end
      repeat (3) @(negedge clk);
      clr_status = (r == 1);
      @(negedge clk);
      clr_status = 1'b0;
      exp_urun = (r == 1) ? 1 : exp_urun + 1;
      vectors++;
      if ({underrun, urun_cnt} !== {1'b1, 8'(exp_urun)}) begin
        miscompares++;
        $display("FAIL clr_vs_underrun: round=%0d underrun=%b urun_cnt=%0d required 1/%0d", r, underrun, urun_cnt, exp_urun);
      end
      en = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_prefill();
    test_reset_mid_play();
    test_cadence();
    test_underrun(1'b1);
    test_underrun(1'b0);
    test_overflow();
    test_clear();
    test_full_write();
    test_disable();
    test_clr_vs_underrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
